mopshub_uplink_arbiter: RTL and testbench
=========================================

Name: mopshub_uplink_arbiter

Overview:
- Round-robin scheduler that shares the single e-link uplink between up to 16 CAN bus receivers.
- Each bus receiver raises a request when it holds a decoded 76-bit frame. The arbiter selects one bus and drives can_rec_select so the top-level mux routes that frame onto data_rec_uplink. It then triggers the e-link transmitter and waits for completion or timeout before serving the next bus.
- Sits inside mopshub_top between the CAN receive cores and the e-link transmit path.

Parameters:
TIMEOUT_CYC, 2048, clock cycles allowed between start_elink_tx and elink_tx_done before the transfer is aborted
CNT_W, 16, width of the forwarded-frame counter

Ports:
clk  input  1  system clock (40 MHz)
rst  input  1  asynchronous active-low reset
n_buses  input  5  highest valid bus index (15 = all 16 buses); values >15 are treated as 15
bus_en_mask  input  16  per-bus enable; 0 = requests from that bus are ignored
can_rec_req  input  16  per-bus frame-ready level; held by the receiver until its ack
abort  input  1  synchronous abort (driven by endwait_all)
elink_tx_done  input  1  one-cycle pulse from the e-link transmitter when the frame has been sent
can_rec_select  output  5  index of the granted bus
grant_valid  output  1  high while a grant is active (GRANT..WAIT states)
start_elink_tx  output  1  one-cycle pulse that starts the uplink transfer
can_rec_ack  output  16  one-hot one-cycle pulse that releases the served bus request
timeout_err  output  1  one-cycle pulse when a transfer times out
err_bus_id  output  5  bus index of the last timeout, held until the next timeout
frame_cnt  output  CNT_W  frames forwarded successfully; saturates at all-ones

Behaviour:
- Reset (rst=0, async): state=IDLE, rr_ptr=15, can_rec_select=0, all other outputs 0, timer=0.
- Eligible vector: elig[i] = can_rec_req[i] & bus_en_mask[i] & (i <= min(n_buses,15)).
- Winner: first set bit of elig, searching circularly from rr_ptr+1 (mod 16) upward. The search is combinational within the cycle.

State machine:
- IDLE
  - If abort=1: stay in IDLE.
  - Else if elig != 0: register winner into can_rec_select and go to GRANT.
- GRANT (1 cycle)
  - grant_valid=1, start_elink_tx=1, timer cleared; then go to WAIT.
- WAIT
  - grant_valid=1; timer increments each cycle.
  - elink_tx_done=1: can_rec_ack[sel]=1 for 1 cycle, frame_cnt+1 (saturating), rr_ptr=sel, go to GAP.
  - Else if timer reaches TIMEOUT_CYC-1: timeout_err=1, err_bus_id=sel, can_rec_ack[sel]=1 (frame dropped), rr_ptr=sel, go to GAP.
  - If done and timeout occur in the same cycle, done wins: no error, counter increments.
- GAP (1 cycle)
  - grant_valid=0; go to IDLE. This cycle lets the receiver drop its request after the ack.

Latency:
- Request seen in IDLE at cycle N → grant registered at N+1 → start_elink_tx at N+1 (GRANT).
- Minimum per-frame turnaround is 4 cycles plus transmitter time.

Boundary conditions:
- Request drops during WAIT: the transfer completes normally and the ack is still issued.
- Mask bit cleared or n_buses lowered during WAIT: the current transfer completes; the change affects only the next arbitration.
- abort in GRANT/WAIT: return to IDLE next cycle, grant_valid=0, no ack, no counter change, no error; rr_ptr unchanged. abort in GAP is ignored; GAP still exits to IDLE.
- elink_tx_done outside WAIT is ignored.
- rr_ptr wraps 15→0; with n_buses<15, indices above n_buses are never granted.
- Simultaneous requests from all buses are served in strict rotation: no bus is granted twice before every other eligible bus has been granted once.

Test Plan:
- Reset then single request on bus 3, done 10 cycles after start → can_rec_select=3, start_elink_tx 1 cycle after request, can_rec_ack=0x0008 pulse, frame_cnt=1.
- can_rec_req=0xFFFF with n_buses=15, mask=0xFFFF, done every transfer → grant order 0,1,…,15,0; frame_cnt=17 after 17 transfers.
- n_buses=4, mask=0xFFEF, req=0xFFFF → grant order 0,1,2,3,0; buses 4–15 never granted.
- No done on bus 7 → timeout_err exactly TIMEOUT_CYC cycles after start, err_bus_id=7, can_rec_ack=0x0080, frame_cnt unchanged; next grant goes to the next eligible bus after 7.
- abort pulse during WAIT on bus 2 → grant_valid low next cycle, no ack, no error; bus 2 is regranted on the next arbitration (rr_ptr unchanged).
- Async reset asserted mid-WAIT → all outputs 0 immediately; the first grant after release is bus 0 when all buses request; frame_cnt forced to 0xFFFF then one more done → stays 0xFFFF.

Source files
------------

// File: rtl/mopshub_uplink_arbiter_if.sv
// Handshake bundle between the uplink arbiter, the CAN receive cores and the e-link transmitter.
// The slave modport is the arbiter side; the master modport is the receiver/transmitter side.
interface mopshub_uplink_arbiter_if;
  logic [15:0] can_rec_req;
  logic [15:0] can_rec_ack;
  logic [4:0]  can_rec_select;
  logic        grant_valid;
  logic        start_elink_tx;
  logic        elink_tx_done;

  modport slave (
    input  can_rec_req,
    input  elink_tx_done,
    output can_rec_ack,
    output can_rec_select,
    output grant_valid,
    output start_elink_tx
  );

  modport master (
    output can_rec_req,
    output elink_tx_done,
    input  can_rec_ack,
    input  can_rec_select,
    input  grant_valid,
    input  start_elink_tx
  );
endinterface

// File: rtl/mopshub_uplink_arbiter.sv
// Round-robin scheduler sharing the single e-link uplink between up to 16 CAN bus receivers.
// One frame is in flight at a time; each transfer ends on done, timeout or abort.
module mopshub_uplink_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 2048,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [4:0]           n_buses_i,
  input  logic [15:0]          bus_en_mask_i,
  input  logic                 abort_i,
  mopshub_uplink_arbiter_if.slave up_if,
  output logic                 timeout_err_o,
  output logic [4:0]           err_bus_id_o,
  output logic [CNT_W-1:0]     frame_cnt_o
);

  localparam int unsigned TimerW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {StIdle, StGrant, StWait, StGap} state_e;

  state_e              state_q, state_d;
  logic [3:0]          rr_ptr_q, rr_ptr_d;
  logic [4:0]          sel_q, sel_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [4:0]          err_id_q, err_id_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [3:0]  lim;
  logic [15:0] elig;
  logic        win_found;
  logic [3:0]  win_idx;
  logic [3:0]  cand;
  logic        timer_exp;

  assign timer_exp = (timer_q == TimerW'(TIMEOUT_CYC - 1));

  // Circular first-set search starting one past the last served bus.
  always_comb begin
    lim       = (n_buses_i > 5'd15) ? 4'd15 : n_buses_i[3:0];
    elig      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < 16; i++) begin
      elig[i] = up_if.can_rec_req[i] & bus_en_mask_i[i] & (4'(i) <= lim);
    end
    for (int k = 1; k <= 16; k++) begin
      cand = rr_ptr_q + 4'(k);
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      rr_ptr_q <= 4'd15;
      sel_q    <= '0;
      timer_q  <= '0;
      err_id_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      sel_q    <= sel_d;
      timer_q  <= timer_d;
      err_id_q <= err_id_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    sel_d    = sel_q;
    timer_d  = timer_q;
    err_id_d = err_id_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (!abort_i && win_found) begin
          sel_d   = {1'b0, win_idx};
          state_d = StGrant;
        end
      end
      StGrant: begin
        timer_d = '0;
        state_d = abort_i ? StIdle : StWait;
      end
      StWait: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (up_if.elink_tx_done) begin
          // Done beats a coincident timeout.
          cnt_d    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
          rr_ptr_d = sel_q[3:0];
          state_d  = StGap;
        end else if (timer_exp) begin
          err_id_d = sel_q;
          rr_ptr_d = sel_q[3:0];
          state_d  = StGap;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    up_if.can_rec_ack    = '0;
    up_if.grant_valid    = (state_q == StGrant) || (state_q == StWait);
    up_if.start_elink_tx = (state_q == StGrant);
    timeout_err_o        = 1'b0;
    if (state_q == StWait && !abort_i) begin
      if (up_if.elink_tx_done) begin
        up_if.can_rec_ack[sel_q[3:0]] = 1'b1;
      end else if (timer_exp) begin
        up_if.can_rec_ack[sel_q[3:0]] = 1'b1;
        timeout_err_o                 = 1'b1;
      end
    end
  end

  assign up_if.can_rec_select = sel_q;
  assign err_bus_id_o         = err_id_q;
  assign frame_cnt_o          = cnt_q;

endmodule

// File: tb/tb_mopshub_uplink_arbiter.sv
// Directed bench for the uplink arbiter: grant order, timeout, abort, reset and counter saturation.
module tb_mopshub_uplink_arbiter;

  localparam int unsigned TIMEOUT = 2048;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  n_buses;
  logic [15:0] mask;
  logic        abort;
  logic        timeout_err, timeout_err2;
  logic [4:0]  err_bus_id, err_bus_id2;
  logic [15:0] frame_cnt;
  logic [1:0]  frame_cnt2;

  int n_vec = 0;
  int n_err = 0;
  int to_cyc;
  logic ok;

  always #5 clk = ~clk;

  mopshub_uplink_arbiter_if u_if ();
  mopshub_uplink_arbiter_if u_if2 ();

  mopshub_uplink_arbiter #(.TIMEOUT_CYC(TIMEOUT), .CNT_W(16)) u_dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .n_buses_i     (n_buses),
    .bus_en_mask_i (mask),
    .abort_i       (abort),
    .up_if         (u_if.slave),
    .timeout_err_o (timeout_err),
    .err_bus_id_o  (err_bus_id),
    .frame_cnt_o   (frame_cnt)
  );

  // Narrow counter instance to reach saturation quickly.
  mopshub_uplink_arbiter #(.TIMEOUT_CYC(16), .CNT_W(2)) u_sat (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .n_buses_i     (n_buses),
    .bus_en_mask_i (mask),
    .abort_i       (abort),
    .up_if         (u_if2.slave),
    .timeout_err_o (timeout_err2),
    .err_bus_id_o  (err_bus_id2),
    .frame_cnt_o   (frame_cnt2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_start(input string tag, output logic found);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (u_if.start_elink_tx === 1'b1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    if (!found) check({tag, " start"}, 32'(u_if.start_elink_tx), 32'd1);
  endtask

  // Wait for a grant, check the bus, complete with done one cycle into WAIT.
  task automatic xfer(input int exp_sel, input string tag);
    logic        f;
    logic [15:0] e_ack;
    e_ack = 16'h1 << exp_sel;
    wait_start(tag, f);
    check({tag, " sel"}, 32'(u_if.can_rec_select), 32'(exp_sel));
    tick();
    u_if.elink_tx_done = 1'b1;
    #1;
    check({tag, " ack"}, 32'(u_if.can_rec_ack), 32'(e_ack));
    tick();
    u_if.elink_tx_done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n               = 1'b0;
    n_buses             = 5'd15;
    mask                = 16'hFFFF;
    abort               = 1'b0;
    u_if.can_rec_req    = '0;
    u_if.elink_tx_done  = 1'b0;
    u_if2.can_rec_req   = '0;
    u_if2.elink_tx_done = 1'b0;
    #12;
    check("rst select", 32'(u_if.can_rec_select), 32'd0);
    check("rst grant_valid", 32'(u_if.grant_valid), 32'd0);
    check("rst start", 32'(u_if.start_elink_tx), 32'd0);
    check("rst ack", 32'(u_if.can_rec_ack), 32'd0);
    check("rst timeout_err", 32'(timeout_err), 32'd0);
    check("rst err_bus_id", 32'(err_bus_id), 32'd0);
    check("rst frame_cnt", 32'(frame_cnt), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();

    // Single request on bus 3, done 10 cycles after start.
    u_if.can_rec_req = 16'h0008;
    #1;
    check("t1 idle grant_valid", 32'(u_if.grant_valid), 32'd0);
    tick();
    check("t1 start", 32'(u_if.start_elink_tx), 32'd1);
    check("t1 select", 32'(u_if.can_rec_select), 32'd3);
    check("t1 grant_valid", 32'(u_if.grant_valid), 32'd1);
    repeat (10) tick();
    check("t1 wait ack", 32'(u_if.can_rec_ack), 32'd0);
    u_if.elink_tx_done = 1'b1;
    #1;
    check("t1 ack", 32'(u_if.can_rec_ack), 32'h0008);
    tick();
    u_if.elink_tx_done = 1'b0;
    u_if.can_rec_req   = '0;
    check("t1 gap ack", 32'(u_if.can_rec_ack), 32'd0);
    check("t1 gap grant_valid", 32'(u_if.grant_valid), 32'd0);
    check("t1 frame_cnt", 32'(frame_cnt), 32'd1);
    tick();

    // All 16 buses requesting; n_buses above 15 clamps to 15.
    do_reset();
    n_buses          = 5'd20;
    u_if.can_rec_req = 16'hFFFF;
    for (int i = 0; i < 17; i++) xfer(i % 16, "t2");
    check("t2 frame_cnt", 32'(frame_cnt), 32'd17);
    u_if.can_rec_req = '0;

    // n_buses=4 with bus 4 masked: only 0..3 rotate.
    do_reset();
    n_buses          = 5'd4;
    mask             = 16'hFFEF;
    u_if.can_rec_req = 16'hFFFF;
    for (int i = 0; i < 5; i++) xfer(i % 4, "t3");
    check("t3 frame_cnt", 32'(frame_cnt), 32'd5);
    u_if.can_rec_req = '0;
    n_buses          = 5'd15;
    mask             = 16'hFFFF;

    // Timeout on bus 7, then the next grant goes to bus 9.
    do_reset();
    u_if.can_rec_req = 16'h0080;
    wait_start("t4", ok);
    check("t4 select", 32'(u_if.can_rec_select), 32'd7);
    u_if.can_rec_req = 16'h0288;
    to_cyc = 0;
    for (int k = 1; k <= int'(TIMEOUT) + 8; k++) begin
      tick();
      if (timeout_err === 1'b1) begin
        to_cyc = k;
        break;
      end
    end
    check("t4 timeout cycles", 32'(to_cyc), TIMEOUT);
    check("t4 ack", 32'(u_if.can_rec_ack), 32'h0080);
    check("t4 frame_cnt", 32'(frame_cnt), 32'd0);
    tick();
    check("t4 err_bus_id", 32'(err_bus_id), 32'd7);
    check("t4 timeout_err pulse", 32'(timeout_err), 32'd0);
    xfer(9, "t4 next");
    u_if.can_rec_req = '0;
    tick();
    u_if.elink_tx_done = 1'b1;
    tick();
    u_if.elink_tx_done = 1'b0;
    check("t4 done ignored", 32'(frame_cnt), 32'd1);
    check("t4 err_bus_id held", 32'(err_bus_id), 32'd7);

    // Abort during WAIT on bus 2; bus 2 is regranted.
    do_reset();
    u_if.can_rec_req = 16'h0024;
    wait_start("t5", ok);
    check("t5 select", 32'(u_if.can_rec_select), 32'd2);
    tick();
    tick();
    abort = 1'b1;
    #1;
    check("t5 abort ack", 32'(u_if.can_rec_ack), 32'd0);
    check("t5 abort timeout_err", 32'(timeout_err), 32'd0);
    tick();
    abort = 1'b0;
    check("t5 grant_valid", 32'(u_if.grant_valid), 32'd0);
    check("t5 frame_cnt", 32'(frame_cnt), 32'd0);
    xfer(2, "t5 regrant");
    check("t5 frame_cnt after", 32'(frame_cnt), 32'd1);
    u_if.can_rec_req = '0;

    // Async reset mid-WAIT.
    do_reset();
    u_if.can_rec_req = 16'hFFFF;
    xfer(0, "t6a");
    xfer(1, "t6b");
    wait_start("t6c", ok);
    check("t6 select", 32'(u_if.can_rec_select), 32'd2);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6 rst grant_valid", 32'(u_if.grant_valid), 32'd0);
    check("t6 rst select", 32'(u_if.can_rec_select), 32'd0);
    check("t6 rst frame_cnt", 32'(frame_cnt), 32'd0);
    check("t6 rst ack", 32'(u_if.can_rec_ack), 32'd0);
    rst_n = 1'b1;
    tick();
    xfer(0, "t6 after");
    u_if.can_rec_req = '0;

    // Saturating counter on the 2-bit instance.
    u_if2.can_rec_req = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 40 && u_if2.start_elink_tx !== 1'b1; j++) tick();
      check("sat start", 32'(u_if2.start_elink_tx), 32'd1);
      tick();
      u_if2.elink_tx_done = 1'b1;
      tick();
      u_if2.elink_tx_done = 1'b0;
      check("sat frame_cnt", 32'(frame_cnt2), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    u_if2.can_rec_req = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
